// File: rtl/bitcnt_ctrl.sv
// Zbb count controller: folds clz/ctz onto a shared popcount core, 2-stage registered pipeline.
// Optional clz/ctz pre-conditioning is enabled by defining BITCNT_CLZ_CTZ_EN.
module bitcnt_ctrl #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_operand,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);

`ifdef BITCNT_CLZ_CTZ_EN
    function automatic logic [31:0] smear(input logic [31:0] x);
        logic [31:0] s;
        s = x | (x >> 1);
        s = s | (s >> 2);
        s = s | (s >> 4);
        s = s | (s >> 8);
        s = s | (s >> 16);
        return s;
    endfunction
`endif

    // Returns {err, t}: clz/ctz are rewritten so their answer is popcount(t).
    function automatic logic [32:0] precondition(input logic [1:0] op, input logic [31:0] x);
        logic [32:0] r;
        r = {1'b1, 32'd0};
        case (op)
            2'b00: r = {1'b0, x};
`ifdef BITCNT_CLZ_CTZ_EN
            2'b01: r = {1'b0, ~smear(x)};
            2'b10: r = {1'b0, ~x & (x - 32'd1)};
`endif
            default: r = {1'b1, 32'd0};
        endcase
        return r;
    endfunction

    function automatic logic [5:0] popcount(input logic [31:0] t);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + {5'd0, t[i]};
        end
        return cnt;
    endfunction

    logic [31:0]      t_p1;
    logic [TAG_W-1:0] tag_p1;
    logic             err_p1;
    logic             vld_p1;
    logic [5:0]       cnt_p2;
    logic [TAG_W-1:0] tag_p2;
    logic             err_p2;
    logic             vld_p2;

    logic [32:0] pre;
    logic        s2_load;
    logic        s1_free;
    logic        accept;

    assign pre       = precondition(req_op, req_operand);
    assign s2_load   = vld_p1 && (!vld_p2 || rsp_ready);
    assign s1_free   = !vld_p1 || s2_load;
    assign req_ready = !flush && !rst && s1_free;
    assign accept    = req_valid && req_ready;

    assign rsp_valid = vld_p2;
    assign rsp_data  = {26'd0, cnt_p2};
    assign rsp_err   = err_p2;
    assign rsp_tag   = tag_p2;
    assign busy      = vld_p1 || vld_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            t_p1   <= 32'd0;
            tag_p1 <= '0;
            err_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            cnt_p2 <= 6'd0;
            tag_p2 <= '0;
            err_p2 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            // stage 2: popcount of the pre-conditioned operand, held while stalled
            if (s2_load) begin
                vld_p2 <= 1'b1;
                cnt_p2 <= popcount(t_p1);
                tag_p2 <= tag_p1;
                err_p2 <= err_p1;
            end else if (rsp_ready) begin
                vld_p2 <= 1'b0;
            end
            // stage 1: capture transformed operand
            if (accept) begin
                vld_p1 <= 1'b1;
                t_p1   <= pre[31:0];
                err_p1 <= pre[32];
                tag_p1 <= req_tag;
            end else if (s2_load) begin
                vld_p1 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bitcnt_ctrl.sv
// Scoreboard bench for bitcnt_ctrl: directed edge cases, backpressure, flush, reset and random traffic.
module tb_bitcnt_ctrl;
    localparam int TAG_W = 5;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [31:0]      req_operand;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;

    bitcnt_ctrl #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_operand(req_operand), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_tag(rsp_tag), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             err;
        int               acc;
        bit               lat;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   lat_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: count bits directly instead of transforming the operand.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] x, input logic [TAG_W-1:0] tag);
        exp_t e;
        int n;
        int i;
        e.tag = tag;
        e.err = 1'b0;
        e.acc = 0;
        e.lat = 0;
        n = 0;
        case (op)
            2'd0: for (int k = 0; k < 32; k++) if (x[k]) n++;
`ifdef BITCNT_CLZ_CTZ_EN
            2'd1: begin
                i = 31;
                while (i >= 0 && !x[i]) begin n++; i--; end
            end
            2'd2: while (n < 32 && !x[n]) n++;
`endif
            default: e.err = 1'b1;
        endcase
        e.data = e.err ? 32'd0 : 32'(n);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    task automatic step(input logic v, input logic [1:0] op, input logic [31:0] x,
                        input logic [TAG_W-1:0] tag, input logic rr, input logic fl,
                        input bit use_lit, input logic lerr, input logic [31:0] ldata,
                        output logic took);
        exp_t e;
        @(negedge clk);
        req_valid = v; req_op = op; req_operand = x; req_tag = tag;
        rsp_ready = rr; flush = fl;
        #1;
        took = v && req_ready;
        if (fl || rst) begin
            q.delete();
        end else if (took) begin
            e = model(op, x, tag);
            if (use_lit) begin
                e.err  = lerr;
                e.data = ldata;
            end
            e.acc = cyc;
            e.lat = lat_mode;
            q.push_back(e);
        end
    endtask

    task automatic idle();
        logic t;
        step(1'b0, 2'd0, 32'd0, '0, 1'b1, 1'b0, 0, 1'b0, 32'd0, t);
    endtask

    task automatic send_lit(input logic [1:0] op, input logic [31:0] x, input logic [TAG_W-1:0] tag,
                            input logic lerr, input logic [31:0] ldata, input string nm);
        logic t;
        step(1'b1, op, x, tag, 1'b1, 1'b0, 1, lerr, ldata, t);
        chk(nm, {31'd0, t}, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || q.size() != 0) && n < 60) begin
            idle();
            n++;
        end
        chk("drain", {31'd0, (busy || q.size() != 0)}, 32'd0);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({nm, "_rsp_data"}, rsp_data, 32'd0);
        chk({nm, "_rsp_tag"}, {27'd0, rsp_tag}, 32'd0);
        chk({nm, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // Monitor: pops the scoreboard on every response handshake and checks hold stability.
    logic             hold_prev = 1'b0;
    logic [31:0]      hold_data;
    logic [TAG_W-1:0] hold_tag;
    logic             hold_err;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && !flush) begin
                if (hold_prev && rsp_valid) begin
                    chk("hold_data", rsp_data, hold_data);
                    chk("hold_tag", {27'd0, rsp_tag}, {27'd0, hold_tag});
                    chk("hold_err", {31'd0, rsp_err}, {31'd0, hold_err});
                end
                hold_prev = rsp_valid && !rsp_ready;
                hold_data = rsp_data;
                hold_tag  = rsp_tag;
                hold_err  = rsp_err;
                if (rsp_valid && rsp_ready) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_rsp: got data %0h tag %0h, want no response", rsp_data, rsp_tag);
                    end else begin
                        e = q.pop_front();
                        chk("rsp_data", rsp_data, e.data);
                        chk("rsp_tag", {27'd0, rsp_tag}, {27'd0, e.tag});
                        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                        if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd2);
                    end
                end
            end else begin
                hold_prev = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        logic took;
        int   idx;
        int   acc_n;
        logic [31:0] bp_ops [3];
        logic [31:0] x;
        int   r;

        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = 2'd0;
        req_operand = 32'd0; req_tag = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset");
        chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_reset_req_ready", {31'd0, req_ready}, 32'd1);

        // basic cpop with latency check, then edge operands back to back
        lat_mode = 1;
        send_lit(2'd0, 32'hF0F0_0001, 5'd3, 1'b0, 32'd9, "accept_cpop");
        drain();
`ifdef BITCNT_CLZ_CTZ_EN
        send_lit(2'd1, 32'h0000_0000, 5'd1, 1'b0, 32'd32, "accept_clz0");
        send_lit(2'd1, 32'h0001_0000, 5'd2, 1'b0, 32'd15, "accept_clz16");
        send_lit(2'd2, 32'h0000_0000, 5'd4, 1'b0, 32'd32, "accept_ctz0");
        send_lit(2'd2, 32'h8000_0000, 5'd5, 1'b0, 32'd31, "accept_ctz31");
`else
        send_lit(2'd1, 32'h0000_0001, 5'd1, 1'b1, 32'd0, "accept_clz_off");
        send_lit(2'd2, 32'h8000_0000, 5'd2, 1'b1, 32'd0, "accept_ctz_off");
`endif
        send_lit(2'd0, 32'hFFFF_FFFF, 5'd6, 1'b0, 32'd32, "accept_cpop_ones");
        send_lit(2'd3, 32'h1234_5678, 5'd7, 1'b1, 32'd0, "accept_reserved");
        drain();

        // streaming 1,3,7,F -> 1..4 on consecutive cycles
        send_lit(2'd0, 32'h1, 5'd8, 1'b0, 32'd1, "stream0");
        send_lit(2'd0, 32'h3, 5'd9, 1'b0, 32'd2, "stream1");
        send_lit(2'd0, 32'h7, 5'd10, 1'b0, 32'd3, "stream2");
        send_lit(2'd0, 32'hF, 5'd11, 1'b0, 32'd4, "stream3");
        drain();
        lat_mode = 0;

        // backpressure: only two fit while rsp_ready is low
        bp_ops[0] = 32'h0000_00FF; bp_ops[1] = 32'h0F00_0000; bp_ops[2] = 32'hAAAA_AAAA;
        idx = 0;
        acc_n = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 2'd0, bp_ops[idx], TAG_W'(12 + idx), 1'b0, 1'b0, 0, 1'b0, 32'd0, took);
            if (took) begin idx++; acc_n++; end
        end
        chk("bp_accepted", 32'(acc_n), 32'd2);
        chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
        chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        step(1'b1, 2'd0, bp_ops[2], 5'd14, 1'b1, 1'b0, 0, 1'b0, 32'd0, took);
        chk("bp_release_accept", {31'd0, took}, 32'd1);
        drain();

        // flush with two in flight and a request offered
        step(1'b1, 2'd0, 32'h3, 5'd20, 1'b1, 1'b0, 0, 1'b0, 32'd0, took);
        step(1'b1, 2'd0, 32'h7, 5'd21, 1'b1, 1'b0, 0, 1'b0, 32'd0, took);
        step(1'b1, 2'd0, 32'hF, 5'd22, 1'b1, 1'b1, 0, 1'b0, 32'd0, took);
        chk("flush_not_consumed", {31'd0, took}, 32'd0);
        idle();
        chk("flush_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        drain();

        // reset mid-operation
        step(1'b1, 2'd0, 32'hFF, 5'd25, 1'b1, 1'b0, 0, 1'b0, 32'd0, took);
        step(1'b1, 2'd0, 32'hF, 5'd26, 1'b1, 1'b0, 0, 1'b0, 32'd0, took);
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0; q.delete();
        @(negedge clk);
        #1;
        check_zero("midreset");
        rst = 1'b0;
        drain();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 3);
            case (r)
                0: x = 32'd0;
                1: x = 32'd1 << $urandom_range(0, 31);
                2: x = 32'hFFFF_FFFF >> $urandom_range(0, 31);
                default: x = $urandom;
            endcase
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), x,
                 TAG_W'($urandom_range(0, 31)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 39) == 0, 0, 1'b0, 32'd0, took);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
